counter_updown_nbit: RTL

- Parametrised synchronous up/down counter: WIDTH-bit, parallel load, runtime-programmable upper limit, wrap or saturate at the boundaries.
- Generalises the 4-bit up/down load counter for timers, address generators and modulo sequencers.
- Adds:
  - a registered terminal-count pulse;
  - a sticky overflow flag.
- Uses a true clock-enable; there is no gated clock.

---
 rtl/counter_updown_nbit.sv | 90 +++++++++
 1 files changed

// File: rtl/counter_updown_nbit.sv
// counter_updown_nbit
//   WIDTH-bit synchronous up/down counter with parallel load, a runtime
//   upper limit, and wrap or saturate behaviour at the boundaries.
//   Adds a registered terminal-count pulse and a sticky overflow flag.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   en       in   count enable (load acts regardless)
//   upDown   in   1 = up, 0 = down
//   load     in   parallel load of d (clamped to limit)
//   d        in   load data [WIDTH]
//   limit    in   upper bound of range 0..limit [WIDTH]
//   sat_mode in   0 = wrap, 1 = saturate
//   clr_ovf  in   clear sticky ovf (a same-edge boundary event wins)
//   q        out  registered count [WIDTH]
//   tc       out  one-cycle pulse after each boundary event
//   ovf      out  sticky boundary flag
module counter_updown_nbit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             upDown,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ResetQ = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_next;
  logic             w_boundary;

  always_comb begin
    w_q_next   = r_q;
    w_boundary = 1'b0;
    if (load) begin
      w_q_next = (d > limit) ? limit : d;
    end else if (en) begin
      if (upDown) begin
        if (r_q < limit) begin
          w_q_next = r_q + 1'b1;
        end else begin
          w_boundary = 1'b1;
          w_q_next   = sat_mode ? limit : '0;
        end
      end else begin
        if (r_q > limit) begin
          // limit was lowered below q: pull back into range, not a boundary
          w_q_next = limit;
        end else if (r_q != '0) begin
          w_q_next = r_q - 1'b1;
        end else begin
          w_boundary = 1'b1;
          w_q_next   = sat_mode ? '0 : limit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= ResetQ;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_tc  <= w_boundary;
      // set has priority over clear
      r_ovf <= w_boundary | (r_ovf & ~clr_ovf);
    end
  end

  assign q   = r_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

endmodule
